iob_cache_be_responder: RTL
===========================

// Module: iob_cache_be_responder
// PURPOSE
//  IOb native slave that answers the cache back-end master (be_valid/addr/wdata/wstrb -> be_ready/rvalid/rdata).
//  Backs a word-addressed byte-enable RAM with programmable read latency and write stall.
//  Stands in for the DDR controller or next-level cache during cache simulation and FPGA bring-up.
//  Also counts accepted transactions and flags out-of-range addresses.
// PARAMETERS
//  ADDR_W      24  byte-address width of be_addr_i (matches cache BE_ADDR_W)
//  DATA_W      32  data width (matches cache BE_DATA_W); multiple of 8
//  MEM_ADDR_W  10  log2 of RAM depth in DATA_W words
//  RD_LAT       2  cycles from read acceptance to rvalid; legal range 1..15
//  WR_LAT       0  extra cycles ready stays low after a write; legal range 0..15
//  CNT_W       32  width of the transaction counters
// PORTS
//  clk_i          in   1              clock
//  rst_n_i        in   1              reset, synchronous, active-low
//  cke_i          in   1              clock enable; low freezes all state
//  be_valid_i     in   1              request valid
//  be_addr_i      in   ADDR_W         byte address
//  be_wdata_i     in   DATA_W         write data
//  be_wstrb_i     in   DATA_W/8       byte strobes; all-zero means read
//  be_ready_o     out  1              request accepted when valid&ready
//  be_rvalid_o    out  1              read data valid, 1-cycle pulse
//  be_rdata_o     out  DATA_W         read data
//  rd_cnt_o       out  CNT_W          accepted reads, saturating
//  wr_cnt_o       out  CNT_W          accepted writes, saturating
//  oob_o          out  1              sticky: an accepted addr had nonzero bits above the RAM range
// BEHAVIOUR
//  Reset (rst_n_i=0 at a rising edge): state=IDLE, ready=0 while in reset, rvalid=0, rdata=0, counters=0, oob=0.
//   RAM contents are not reset.
//  Reset mid-operation drops any pending read; no rvalid is produced for it.
//  Word index = addr[MEM_ADDR_W+log2(DATA_W/8)-1 : log2(DATA_W/8)]; low byte-offset bits are ignored.
//  Higher address bits alias onto the RAM; if any is 1 on an accepted request, oob_o is set (sticky until reset).
//  FSM states: IDLE, RD_WAIT, WR_WAIT. ready_o=1 only in IDLE.
//  IDLE + valid & wstrb==0: the read is accepted at cycle t. RAM word is sampled at t.
//   RD_LAT==1: stay IDLE.
//   RD_LAT>1: go to RD_WAIT with cnt=RD_LAT-2.
//  RD_WAIT: decrement cnt each cycle; at cnt==0 return to IDLE.
//   This gives rvalid=1 and rdata valid exactly in cycle t+RD_LAT, and ready=1 in that same cycle, so back-to-back requests are allowed.
//  IDLE + valid & wstrb!=0: the write is accepted at t. Bytes with wstrb[i]=1 are written at the edge ending t; other bytes keep their value. No rvalid is produced.
//   WR_LAT>0: go to WR_WAIT with cnt=WR_LAT-1. ready=0 for cycles t+1..t+WR_LAT, then return to IDLE.
//  Read accepted at t+1 after a write at t returns the new data (write-then-read ordering).
//  be_rdata_o holds its last value until the next rvalid.
//  valid=0 in IDLE: no state change. A request is taken only when valid&ready; a request deasserted before acceptance has no effect.
//  Counters increment once per accepted request and saturate at all-ones.
//  cke_i=0: FSM, cnt, RAM, counters and outputs hold; a cycle with cke_i=0 does not count toward RD_LAT/WR_LAT and accepts nothing.
//  Width rules: cnt is 4 bits. The wstrb==0 test covers the full strobe width.
// STRUCTURE
//  Shared package iob_cache_be_responder_pkg holds:
//   - state encodings: IDLE=2'd0, RD_WAIT=2'd1, WR_WAIT=2'd2
//   - LAT_CNT_W=4
//   - function nbytes_w(DATA_W)
//  One sub-module: iob_cache_be_ram, a single-port byte-enable RAM, DATA_W x 2**MEM_ADDR_W, with registered read and write-first on the same word.
//  The top holds the FSM, latency counter, counters and oob flag.
// TESTING
//  1 Reset then idle: rst_n_i=0 for 3 cycles, then 1 -> ready=1 on the first cycle after release; rvalid=0, rdata=0, counters=0, oob=0.
//  2 Write then read, RD_LAT=2: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then read 0x10 at the next cycle -> rvalid 2 cycles after acceptance, rdata=0xDEADBEEF, ready low for 1 cycle.
//  3 Partial strobe: word holds 0x11223344; write 0xAABBCCDD with wstrb 0x5 -> a later read returns 0x11BB33DD; wr_cnt=2.
//  4 WR_LAT=3 stall: one write, then valid held high with a read -> ready low for exactly 3 cycles, then the read is accepted.
//  5 Out-of-range: MEM_ADDR_W=10, read addr 0x1000 -> returns word 0 (alias), oob_o=1 and it stays set after further in-range accesses.
//  6 Reset mid-read, RD_LAT=4: assert rst_n_i=0 two cycles after acceptance -> no rvalid ever appears for that read; rd_cnt=0 after reset.

Source files
------------

// File: rtl/iob_cache_be_responder_pkg.sv
// Shared types and helpers for the cache back-end responder.
package iob_cache_be_responder_pkg;

    // Responder control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    // Width of the read/write latency down-counter
    localparam int LAT_CNT_W = 4;

    // Number of byte-offset bits in a DATA_W-wide word address
    function automatic int nbytes_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/iob_cache_be_ram.sv
// Single-port byte-enable RAM with registered, write-first read.
module iob_cache_be_ram #(
    parameter int DATA_W = 32,
    parameter int AW     = 10
) (
    input  logic                clk_i,
    input  logic                en_i,
    input  logic [DATA_W/8-1:0] we_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [2**AW];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] merged_d;

    // Stored word with the strobed bytes replaced by incoming data
    always_comb begin
        // NOTE: merged_d gets a full default before any conditional update, so no latch is inferred.
        merged_d = mem_q[addr_i];
        for (int i = 0; i < NB; i++) begin
            if (we_i[i]) begin
                merged_d[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

    // Write strobed bytes and register the merged word (write-first)
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; RAM contents are deliberately left as-is so it maps onto block RAM.
        if (en_i) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            mem_q[addr_i] <= merged_d;
            rdata_q       <= merged_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/iob_cache_be_responder.sv
// IOb native slave answering the cache back-end master from a local RAM,
// with programmable read latency, write stall, counters and an OOB flag.
module iob_cache_be_responder
    import iob_cache_be_responder_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int RD_LAT     = 2,
    parameter int WR_LAT     = 0,
    parameter int CNT_W      = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cke_i,
    input  logic                be_valid_i,
    input  logic [ADDR_W-1:0]   be_addr_i,
    input  logic [DATA_W-1:0]   be_wdata_i,
    input  logic [DATA_W/8-1:0] be_wstrb_i,
    output logic                be_ready_o,
    output logic                be_rvalid_o,
    output logic [DATA_W-1:0]   be_rdata_o,
    output logic [CNT_W-1:0]    rd_cnt_o,
    output logic [CNT_W-1:0]    wr_cnt_o,
    output logic                oob_o
);

    localparam int OFF_W   = nbytes_w(DATA_W);
    localparam int WORD_HI = MEM_ADDR_W + OFF_W;

    localparam logic [LAT_CNT_W-1:0] RD_CNT_INIT = LAT_CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
    localparam logic [LAT_CNT_W-1:0] WR_CNT_INIT = LAT_CNT_W'((WR_LAT > 0) ? WR_LAT - 1 : 0);

    state_t                 state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_W-1:0]      rdata_hold_q, rdata_hold_d;
    logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic                   oob_q, oob_d;

    logic                   accept;
    logic                   is_read;
    logic                   addr_hi_set;
    logic [DATA_W-1:0]      ram_rdata;

    // Byte-offset bits select nothing in a word-wide RAM
    logic unused_addr_bits;
    assign unused_addr_bits = ^be_addr_i[OFF_W-1:0];

    assign accept      = cke_i & be_valid_i & ready_q;
    assign is_read     = (be_wstrb_i == '0);
    assign addr_hi_set = |be_addr_i[ADDR_W-1:WORD_HI];

    iob_cache_be_ram #(
        .DATA_W (DATA_W),
        .AW     (MEM_ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (accept),
        .we_i    (be_wstrb_i),
        .addr_i  (be_addr_i[WORD_HI-1:OFF_W]),
        .wdata_i (be_wdata_i),
        .rdata_o (ram_rdata)
    );

    // Next-state, latency counting, transaction counters and OOB tracking
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rvalid_d     = 1'b0;
        rdata_hold_d = rdata_hold_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        oob_d        = oob_q;

        // Keep the delivered word visible once the rvalid pulse ends
        if (rvalid_q) begin
            rdata_hold_d = ram_rdata;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (addr_hi_set) begin
                        oob_d = 1'b1;
                    end
                    if (is_read) begin
                        rd_cnt_d = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + CNT_W'(1);
                        if (RD_LAT == 1) begin
                            rvalid_d = 1'b1;
                        end else begin
                            state_d = RD_WAIT;
                            cnt_d   = RD_CNT_INIT;
                        end
                    end else begin
                        wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + CNT_W'(1);
                        if (WR_LAT > 0) begin
                            state_d = WR_WAIT;
                            cnt_d   = WR_CNT_INIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // FSM and registered outputs; reset is synchronous, cke freezes everything
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_hold_q <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            oob_q        <= 1'b0;
        end else if (cke_i) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            rvalid_q     <= rvalid_d;
            rdata_hold_q <= rdata_hold_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            oob_q        <= oob_d;
        end
    end

    assign be_ready_o  = ready_q;
    assign be_rvalid_o = rvalid_q;
    assign be_rdata_o  = rvalid_q ? ram_rdata : rdata_hold_q;
    assign rd_cnt_o    = rd_cnt_q;
    assign wr_cnt_o    = wr_cnt_q;
    assign oob_o       = oob_q;

endmodule
